// File: rtl/regwrite_decoder.sv
// Pipelined one-hot write-enable decoder for a multi-port register file, with zero-register masking,
// same-cycle conflict arbitration and flush. Optional feature macro: REGWRITE_DECODER_STATS_EN (conflict_count).
module regwrite_decoder #(
    parameter int ADDR_W    = 5,
    parameter int NUM_PORTS = 2,
    parameter int LATENCY   = 1,
    parameter int ZERO_REG  = 31,
    parameter int ZERO_EN   = 1,
    localparam int DEC_W    = 2 ** ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_addr,
    input  logic                          flush,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*DEC_W-1:0]    out_onehot,
    output logic [DEC_W-1:0]              out_any,
`ifdef REGWRITE_DECODER_STATS_EN
    output logic [15:0]                   conflict_count,
`endif
    output logic                          conflict
);

    if (NUM_PORTS < 1 || NUM_PORTS > 4 || LATENCY < 1 || LATENCY > 3) begin : g_bad_param
        $error("regwrite_decoder: NUM_PORTS must be 1..4 and LATENCY 1..3");
    end

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_REG[ADDR_W-1:0];
    localparam logic [DEC_W-1:0]  ONE_BIT   = {{(DEC_W-1){1'b0}}, 1'b1};

    logic [NUM_PORTS-1:0]       live_d;
    logic [NUM_PORTS-1:0]       win_d;
    logic [NUM_PORTS*DEC_W-1:0] onehot_d;
    logic                       conflict_d;

    // Input decode: a live write loses if any higher-index live port targets the same register
    always_comb begin
        live_d     = '0;
        win_d      = '0;
        onehot_d   = '0;
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            live_d[p] = in_valid[p] &&
                        !(ZERO_EN != 0 && in_addr[p*ADDR_W +: ADDR_W] == ZERO_ADDR);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            win_d[p] = live_d[p];
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (live_d[q] && in_addr[q*ADDR_W +: ADDR_W] == in_addr[p*ADDR_W +: ADDR_W])
                    win_d[p] = 1'b0;
            end
            if (live_d[p] && !win_d[p])
                conflict_d = 1'b1;
            if (win_d[p])
                onehot_d[p*DEC_W +: DEC_W] = ONE_BIT << in_addr[p*ADDR_W +: ADDR_W];
        end
    end

    logic [NUM_PORTS-1:0]       vld_q      [LATENCY];
    logic [NUM_PORTS*DEC_W-1:0] onehot_q   [LATENCY];
    logic                       conflict_q [LATENCY];

    // Stage 1..LATENCY shift register; flush empties every stage including the incoming request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_q[k]      <= '0;
                onehot_q[k]   <= '0;
                conflict_q[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_q[k]      <= '0;
                onehot_q[k]   <= '0;
                conflict_q[k] <= 1'b0;
            end
        end else begin
            vld_q[0]      <= in_valid;
            onehot_q[0]   <= onehot_d;
            conflict_q[0] <= conflict_d;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k]      <= vld_q[k-1];
                onehot_q[k]   <= onehot_q[k-1];
                conflict_q[k] <= conflict_q[k-1];
            end
        end
    end

    assign out_valid  = vld_q[LATENCY-1];
    assign out_onehot = onehot_q[LATENCY-1];
    assign conflict   = conflict_q[LATENCY-1];

    always_comb begin
        out_any = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            out_any = out_any | onehot_q[LATENCY-1][p*DEC_W +: DEC_W];
    end

`ifdef REGWRITE_DECODER_STATS_EN
    logic        last_conflict_d;
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Count on the edge that loads the output stage so the count tracks the visible conflict
    if (LATENCY == 1) begin : g_last_l1
        assign last_conflict_d = conflict_d;
    end else begin : g_last_ln
        assign last_conflict_d = conflict_q[LATENCY-2];
    end

    always_comb begin
        count_d = count_q;
        if (last_conflict_d && !flush && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign conflict_count = count_q;
`endif

endmodule

// File: tb/tb_regwrite_decoder.sv
// Directed bench for regwrite_decoder across three parameter sets (default, LATENCY=3/ZERO_EN=0, 3-bit/4-port).
module tb_regwrite_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // A: ADDR_W=5, NUM_PORTS=2, LATENCY=1, ZERO_EN=1
    logic [1:0]  va;  logic [9:0] aa;  logic fa;
    logic [1:0]  ova; logic [63:0] oha; logic [31:0] anya; logic cfa;
    // B: ADDR_W=5, NUM_PORTS=2, LATENCY=3, ZERO_EN=0
    logic [1:0]  vb;  logic [9:0] ab;  logic fb;
    logic [1:0]  ovb; logic [63:0] ohb; logic [31:0] anyb; logic cfb;
    // C: ADDR_W=3, NUM_PORTS=4, LATENCY=1, ZERO_REG=7, ZERO_EN=1
    logic [3:0]  vc;  logic [11:0] ac; logic fc;
    logic [3:0]  ovc; logic [31:0] ohc; logic [7:0] anyc; logic cfc;
`ifdef REGWRITE_DECODER_STATS_EN
    logic [15:0] cca, ccb, ccc;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    regwrite_decoder #(.ADDR_W(5), .NUM_PORTS(2), .LATENCY(1), .ZERO_REG(31), .ZERO_EN(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(va), .in_addr(aa), .flush(fa),
        .out_valid(ova), .out_onehot(oha), .out_any(anya),
`ifdef REGWRITE_DECODER_STATS_EN
        .conflict_count(cca),
`endif
        .conflict(cfa));

    regwrite_decoder #(.ADDR_W(5), .NUM_PORTS(2), .LATENCY(3), .ZERO_REG(31), .ZERO_EN(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(vb), .in_addr(ab), .flush(fb),
        .out_valid(ovb), .out_onehot(ohb), .out_any(anyb),
`ifdef REGWRITE_DECODER_STATS_EN
        .conflict_count(ccb),
`endif
        .conflict(cfb));

    regwrite_decoder #(.ADDR_W(3), .NUM_PORTS(4), .LATENCY(1), .ZERO_REG(7), .ZERO_EN(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(vc), .in_addr(ac), .flush(fc),
        .out_valid(ovc), .out_onehot(ohc), .out_any(anyc),
`ifdef REGWRITE_DECODER_STATS_EN
        .conflict_count(ccc),
`endif
        .conflict(cfc));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        va = '0; aa = '0; fa = 1'b0;
        vb = '0; ab = '0; fb = 1'b0;
        vc = '0; ac = '0; fc = 1'b0;
    endtask

    // Reference for config C: walk ports from highest index, first claimant of a register wins
    function automatic logic [31:0] model_c(input logic [3:0] v, input logic [11:0] a, output logic cf);
        logic [7:0]  claimed;
        logic [31:0] res;
        logic [2:0]  ad;
        claimed = '0;
        res     = '0;
        cf      = 1'b0;
        for (int p = 3; p >= 0; p--) begin
            ad = a[p*3 +: 3];
            if (v[p] && ad != 3'd7) begin
                if (claimed[ad]) cf = 1'b1;
                else begin
                    claimed[ad]     = 1'b1;
                    res[p*8 + ad]   = 1'b1;
                end
            end
        end
        return res;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        va = 2'($urandom); aa = 10'($urandom); fa = 1'b0;
        vb = 2'($urandom); ab = 10'($urandom); fb = 1'b0;
        vc = 4'($urandom); ac = 12'($urandom); fc = 1'b0;
        step(); step();
        n_checks++; if ({ova, oha, anya, cfa} !== '0) $display("FAIL reset_a: got %h required 0", {ova, oha, anya, cfa}); else n_pass++;
        n_checks++; if ({ovb, ohb, anyb, cfb} !== '0) $display("FAIL reset_b: got %h required 0", {ovb, ohb, anyb, cfb}); else n_pass++;
        n_checks++; if ({ovc, ohc, anyc, cfc} !== '0) $display("FAIL reset_c: got %h required 0", {ovc, ohc, anyc, cfc}); else n_pass++;
`ifdef REGWRITE_DECODER_STATS_EN
        n_checks++; if (cca !== 16'd0) $display("FAIL reset_count: got %0d required 0", cca); else n_pass++;
`endif
        idle_all();
        reset_n = 1'b1;
        step(); step(); step();
        n_checks++; if ({ova, oha, anya, cfa} !== '0) $display("FAIL idle_a: got %h required 0", {ova, oha, anya, cfa}); else n_pass++;
        n_checks++; if ({ovb, ohb, anyb, cfb} !== '0) $display("FAIL idle_b: got %h required 0", {ovb, ohb, anyb, cfb}); else n_pass++;
    endtask

    task automatic test_single_write();
        va = 2'b01; aa = {5'd0, 5'd3};
        step();
        n_checks++; if (ova !== 2'b01) $display("FAIL single_valid: got %b required 01", ova); else n_pass++;
        n_checks++; if (oha !== {32'h0, 32'h0000_0008}) $display("FAIL single_onehot: got %h required 8", oha); else n_pass++;
        n_checks++; if (anya !== 32'h8) $display("FAIL single_any: got %h required 8", anya); else n_pass++;
        n_checks++; if (cfa !== 1'b0) $display("FAIL single_conflict: got %b required 0", cfa); else n_pass++;
        va = '0;
        step();
        n_checks++; if ({ova, anya} !== '0) $display("FAIL single_drain: got %h required 0", {ova, anya}); else n_pass++;
    endtask

    task automatic test_zero_reg();
        va = 2'b10; aa = {5'd31, 5'd0};
        step();
        n_checks++; if (ova !== 2'b10) $display("FAIL zero_valid: got %b required 10", ova); else n_pass++;
        n_checks++; if (oha !== 64'h0) $display("FAIL zero_onehot: got %h required 0", oha); else n_pass++;
        n_checks++; if ({anya, cfa} !== '0) $display("FAIL zero_any_conflict: got %h required 0", {anya, cfa}); else n_pass++;
        va = 2'b11; aa = {5'd31, 5'd31};
        step();
        n_checks++; if ({ova, oha, cfa} !== {2'b11, 64'h0, 1'b0}) $display("FAIL zero_both: got %h required %h", {ova, oha, cfa}, {2'b11, 64'h0, 1'b0}); else n_pass++;
        va = '0;
        vb = 2'b10; ab = {5'd31, 5'd0};
        step();
        vb = '0;
        step();
        n_checks++; if (ovb !== 2'b00) $display("FAIL zero_b_early: got %b required 00", ovb); else n_pass++;
        step();
        n_checks++; if (ovb !== 2'b10) $display("FAIL zero_b_valid: got %b required 10", ovb); else n_pass++;
        n_checks++; if (ohb !== {32'h8000_0000, 32'h0}) $display("FAIL zero_b_onehot: got %h required %h", ohb, {32'h8000_0000, 32'h0}); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        va = 2'b11; aa = {5'd2, 5'd1};
        step();
        n_checks++; if ({ova, anya, cfa} !== {2'b11, 32'h6, 1'b0}) $display("FAIL b2b_0: got %h required %h", {ova, anya, cfa}, {2'b11, 32'h6, 1'b0}); else n_pass++;
        aa = {5'd30, 5'd3};
        step();
        n_checks++; if (anya !== 32'h4000_0008) $display("FAIL b2b_1: got %h required 40000008", anya); else n_pass++;
        aa = {5'd0, 5'd31};
        step();
        n_checks++; if (oha !== {32'h1, 32'h0}) $display("FAIL b2b_2: got %h required %h", oha, {32'h1, 32'h0}); else n_pass++;
        va = '0;
        step();
    endtask

    task automatic test_conflict();
        va = 2'b11; aa = {5'd7, 5'd7};
        step();
        n_checks++; if (ova !== 2'b11) $display("FAIL conflict_valid: got %b required 11", ova); else n_pass++;
        n_checks++; if (oha !== {32'h80, 32'h0}) $display("FAIL conflict_onehot: got %h required %h", oha, {32'h80, 32'h0}); else n_pass++;
        n_checks++; if (anya !== 32'h80) $display("FAIL conflict_any: got %h required 80", anya); else n_pass++;
        n_checks++; if (cfa !== 1'b1) $display("FAIL conflict_flag: got %b required 1", cfa); else n_pass++;
`ifdef REGWRITE_DECODER_STATS_EN
        n_checks++; if (cca !== 16'd1) $display("FAIL conflict_count1: got %0d required 1", cca); else n_pass++;
`endif
        aa = {5'd12, 5'd12};
        step();
        va = '0;
        n_checks++; if ({anya, cfa} !== {32'h1000, 1'b1}) $display("FAIL conflict_second: got %h required %h", {anya, cfa}, {32'h1000, 1'b1}); else n_pass++;
        step();
        n_checks++; if (cfa !== 1'b0) $display("FAIL conflict_clear: got %b required 0", cfa); else n_pass++;
`ifdef REGWRITE_DECODER_STATS_EN
        n_checks++; if (cca !== 16'd2) $display("FAIL conflict_count2: got %0d required 2", cca); else n_pass++;
`endif
    endtask

    task automatic test_flush();
        // Flush wins over a same-cycle request, including a conflicting one
        va = 2'b11; aa = {5'd9, 5'd9}; fa = 1'b1;
        step();
        va = '0; fa = 1'b0;
        n_checks++; if ({ova, oha, cfa} !== '0) $display("FAIL flush_a: got %h required 0", {ova, oha, cfa}); else n_pass++;
`ifdef REGWRITE_DECODER_STATS_EN
        n_checks++; if (cca !== 16'd2) $display("FAIL flush_keeps_count: got %0d required 2", cca); else n_pass++;
`endif
        vb = 2'b01; ab = {5'd0, 5'd1};
        step();
        ab = {5'd0, 5'd2};
        step();
        ab = {5'd0, 5'd3}; fb = 1'b1;
        step();
        fb = 1'b0;
        n_checks++; if ({ovb, anyb} !== '0) $display("FAIL flush_e3: got %h required 0", {ovb, anyb}); else n_pass++;
        ab = {5'd0, 5'd4};
        step();
        vb = '0;
        n_checks++; if ({ovb, anyb} !== '0) $display("FAIL flush_e4: got %h required 0", {ovb, anyb}); else n_pass++;
        step();
        n_checks++; if ({ovb, anyb} !== '0) $display("FAIL flush_e5: got %h required 0", {ovb, anyb}); else n_pass++;
        step();
        n_checks++; if ({ovb, anyb} !== {2'b01, 32'h10}) $display("FAIL flush_new: got %h required %h", {ovb, anyb}, {2'b01, 32'h10}); else n_pass++;
        step();
    endtask

    task automatic test_reset_midflight();
        vb = 2'b01; ab = {5'd0, 5'd9};
        step();
        vb = '0;
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if ({ovb, ohb} !== '0) $display("FAIL midreset_async: got %h required 0", {ovb, ohb}); else n_pass++;
        step();
        reset_n = 1'b1;
        step(); step(); step();
        n_checks++; if ({ovb, anyb} !== '0) $display("FAIL midreset_discard: got %h required 0", {ovb, anyb}); else n_pass++;
        vb = 2'b10; ab = {5'd4, 5'd0};
        step();
        vb = '0;
        step(); step();
        n_checks++; if ({ovb, ohb} !== {2'b10, 32'h10, 32'h0}) $display("FAIL midreset_first: got %h required %h", {ovb, ohb}, {2'b10, 32'h10, 32'h0}); else n_pass++;
        step();
    endtask

    task automatic test_sweep();
        logic [31:0] exp_oh;
        logic        exp_cf;
        vc = 4'hF; ac = {3'd6, 3'd5, 3'd2, 3'd0};
        step();
        n_checks++; if ({ovc, anyc, cfc} !== {4'hF, 8'h65, 1'b0}) $display("FAIL sweep_distinct: got %h required %h", {ovc, anyc, cfc}, {4'hF, 8'h65, 1'b0}); else n_pass++;
        n_checks++; if (ohc !== 32'h4020_0401) $display("FAIL sweep_distinct_oh: got %h required 40200401", ohc); else n_pass++;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 8; a++) begin
                vc = 4'b0001 << p;
                ac = 12'(a) << (3 * p);
                step();
                exp_oh = (a == 7) ? 32'h0 : (32'h1 << (8 * p + a));
                n_checks++;
                if ({ohc, ovc, cfc} !== {exp_oh, 4'b0001 << p, 1'b0})
                    $display("FAIL sweep_p%0d_a%0d: got %h/%b required %h", p, a, ohc, ovc, exp_oh);
                else n_pass++;
            end
        end
        for (int i = 0; i < 40; i++) begin
            vc = 4'($urandom);
            ac = 12'($urandom);
            exp_oh = model_c(vc, ac, exp_cf);
            step();
            n_checks++;
            if ({ohc, cfc, ovc} !== {exp_oh, exp_cf, vc})
                $display("FAIL sweep_rand%0d: got %h/%b required %h/%b", i, ohc, cfc, exp_oh, exp_cf);
            else n_pass++;
        end
        vc = '0;
        step();
    endtask

    initial begin
        idle_all();
        reset_n = 1'b0;
        test_reset();
        test_single_write();
        test_zero_reg();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_reset_midflight();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
